// File: rtl/ps2_host_tx_if.sv
// Command-side bundle for ps2_host_tx.
//   cmd_valid / cmd_data : byte offered to the transmitter (LSB sent first)
//   cmd_ready            : transmitter idle and able to accept a byte
//   sent                 : one-cycle pulse, frame acknowledged by the device
//   error                : one-cycle pulse, frame aborted
// master = command source, slave = ps2_host_tx.
interface ps2_host_tx_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       sent;
  logic       error;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready,
    input  sent,
    input  error
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready,
    output sent,
    output error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues a request-to-send, then clocks out
// 8 data bits (LSB first), odd parity and stop in step with the device clock, and checks the
// device ACK.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   cmd (slave)         : cmd_valid/cmd_data/cmd_ready handshake plus sent/error pulses
//   ps2_clk_in/dat_in   : raw PS/2 pin levels (asynchronous)
//   ps2_*_drive_low     : 1 pulls the open-drain line low, 0 releases it
// Optional build macro PS2_HOST_TX_TIMEOUT_EN adds start/frame timeouts that abort the frame
// with an error pulse; without it the block waits indefinitely for the device.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned FRAME_TIMEOUT  = 100000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave cmd,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_drive_low,
  output logic         ps2_dat_drive_low
);

  localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  if (INHIBIT_CYCLES == 0 || START_TIMEOUT == 0 || FRAME_TIMEOUT == 0) begin : g_bad_cfg
    $error("ps2_host_tx: INHIBIT_CYCLES, START_TIMEOUT and FRAME_TIMEOUT must be non-zero");
  end

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StWaitFirst,
    StShift,
    StAck,
    StReleaseWait
  } state_e;

  state_e          state_q;
  logic [7:0]      data_q;
  logic            parity_q;
  logic [3:0]      bit_cnt_q;
  logic [InhW-1:0] inh_cnt_q;
  logic            ready_q, clk_low_q, dat_low_q, sent_q, error_q;

  // Two-flop synchronizers; clk_prev_q holds the previous synchronized clock for edge detect.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;
  logic fall;

  assign fall = clk_prev_q & ~clk_sync_q;

  logic start_expired, frame_expired;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int unsigned TmoMax = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
  localparam int unsigned TmoW   = $clog2(TmoMax + 1);

  logic [TmoW-1:0] tmo_q;

  // Restarts on entry to WAIT_FIRST and again at the first device edge, so one counter serves
  // both the start window and the frame window.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else if ((state_q == StWaitFirst && fall) ||
                 !(state_q inside {StWaitFirst, StShift, StAck})) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign start_expired = (state_q == StWaitFirst) && (tmo_q == TmoW'(START_TIMEOUT - 1));
  assign frame_expired = (state_q inside {StShift, StAck}) && (tmo_q == TmoW'(FRAME_TIMEOUT - 1));
`else
  assign start_expired = 1'b0;
  assign frame_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      ready_q    <= 1'b1;
      clk_low_q  <= 1'b0;
      dat_low_q  <= 1'b0;
      sent_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
      sent_q     <= 1'b0;
      error_q    <= 1'b0;

      if (start_expired || frame_expired) begin
        clk_low_q <= 1'b0;
        dat_low_q <= 1'b0;
        error_q   <= 1'b1;
        ready_q   <= 1'b1;
        state_q   <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cmd.cmd_valid) begin
              data_q    <= cmd.cmd_data;
              parity_q  <= ~^cmd.cmd_data;
              ready_q   <= 1'b0;
              clk_low_q <= 1'b1;
              inh_cnt_q <= '0;
              state_q   <= StInhibit;
            end
          end
          StInhibit: begin
            if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
              dat_low_q <= 1'b1;  // start bit
              state_q   <= StReq;
            end else begin
              inh_cnt_q <= inh_cnt_q + 1'b1;
            end
          end
          StReq: begin
            clk_low_q <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= StWaitFirst;
          end
          StWaitFirst: begin
            if (fall) begin
              dat_low_q <= ~data_q[0];
              bit_cnt_q <= 4'd1;
              state_q   <= StShift;
            end
          end
          StShift: begin
            if (fall) begin
              if (bit_cnt_q != 4'hF) bit_cnt_q <= bit_cnt_q + 4'd1;
              // bit_cnt_q is the index of the falling edge minus one.
              if (bit_cnt_q <= 4'd7) begin
                dat_low_q <= ~data_q[bit_cnt_q[2:0]];
              end else if (bit_cnt_q == 4'd8) begin
                dat_low_q <= ~parity_q;
              end else begin
                dat_low_q <= 1'b0;  // stop bit
                state_q   <= StAck;
              end
            end
          end
          StAck: begin
            if (fall) begin
              if (!dat_sync_q) begin
                state_q <= StReleaseWait;
              end else begin
                error_q <= 1'b1;
                ready_q <= 1'b1;
                state_q <= StIdle;
              end
            end
          end
          StReleaseWait: begin
            if (clk_sync_q && dat_sync_q) begin
              sent_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= StIdle;
            end
          end
          default: begin
            ready_q   <= 1'b1;
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            state_q   <= StIdle;
          end
        endcase
      end
    end
  end

  assign cmd.cmd_ready     = ready_q;
  assign cmd.sent          = sent_q;
  assign cmd.error         = error_q;
  assign ps2_clk_drive_low = clk_low_q;
  assign ps2_dat_drive_low = dat_low_q;

endmodule
